// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : decode stage of the 5-stage RV32I pipeline
//
// Decodes Instr_IFID, reads the 32x32 register file (written from WB),
// sign-extends the immediate and registers everything into ID/EX.
//
// Ports
//   clk, rst            clock, async active-high reset
//   Instr_IFID, PC_IFID instruction and its PC from IF/ID
//   FlushE              load a bubble (all zero) into ID/EX at next edge
//   RegWriteW/RdW/ResultW  WB register-file write port
//   Rs1D, Rs2D          combinational source indices for the hazard unit
//   *_IDEX              ID/EX pipeline register outputs
//
// Optional feature: define ID_STAGE_WB_BYPASS_EN to forward a same-cycle
// WB write into RD1/RD2 (write-through). Undefined: reads see the
// pre-write contents and the hazard unit must stall across WB->ID.
// ---------------------------------------------------------------------------
module id_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [XLEN-1:0]       Instr_IFID,
   input  logic [XLEN-1:0]       PC_IFID,
   input  logic                  FlushE,
   input  logic                  RegWriteW,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic [XLEN-1:0]       ResultW,
   output logic [REG_ADDR_W-1:0] Rs1D,
   output logic [REG_ADDR_W-1:0] Rs2D,
   output logic                  RegWrite_IDEX,
   output logic                  MemWrite_IDEX,
   output logic                  Jump_IDEX,
   output logic                  Branch_IDEX,
   output logic                  ALUSrc_IDEX,
   output logic [1:0]            ResultSrc_IDEX,
   output logic [2:0]            ALUControl_IDEX,
   output logic [XLEN-1:0]       RD1_IDEX,
   output logic [XLEN-1:0]       RD2_IDEX,
   output logic [XLEN-1:0]       ImmExt_IDEX,
   output logic [XLEN-1:0]       PC_IDEX,
   output logic [XLEN-1:0]       PCPlus4_IDEX,
   output logic [REG_ADDR_W-1:0] Rs1_IDEX,
   output logic [REG_ADDR_W-1:0] Rs2_IDEX,
   output logic [REG_ADDR_W-1:0] Rd_IDEX
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_write;
      logic                  jump;
      logic                  branch;
      logic                  alu_src;
      logic [1:0]            result_src;
      logic [2:0]            alu_ctrl;
      logic [XLEN-1:0]       rd1;
      logic [XLEN-1:0]       rd2;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       pc4;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
   } idex_t;

   // funct3 -> ALU op; sub only honoured for R-type add/sub
   function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  alu_sel = sub ? 3'b001 : 3'b000;
         3'b111:  alu_sel = 3'b010;
         3'b110:  alu_sel = 3'b011;
         3'b010:  alu_sel = 3'b101;
         default: alu_sel = 3'b000;
      endcase
   endfunction

   logic [XLEN-1:0] rf_q [32];
   logic [XLEN-1:0] rd1, rd2;
   logic [6:0]      opcode;
   idex_t           dec, idex_d, idex_q;

   assign opcode = Instr_IFID[6:0];
   assign Rs1D   = Instr_IFID[19:15];
   assign Rs2D   = Instr_IFID[24:20];

   // Register file; x0 is never written so it stays at its reset value 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (RegWriteW && RdW != '0) begin
         rf_q[RdW] <= ResultW;
      end
   end

   always_comb begin
      rd1 = (Rs1D == '0) ? '0 : rf_q[Rs1D];
      rd2 = (Rs2D == '0) ? '0 : rf_q[Rs2D];
`ifdef ID_STAGE_WB_BYPASS_EN
      if (RegWriteW && RdW != '0 && RdW == Rs1D) rd1 = ResultW;
      if (RegWriteW && RdW != '0 && RdW == Rs2D) rd2 = ResultW;
`endif
   end

   always_comb begin
      dec     = '0;
      dec.rd1 = rd1;
      dec.rd2 = rd2;
      dec.pc  = PC_IFID;
      dec.pc4 = PC_IFID + 32'd4;
      dec.rs1 = Rs1D;
      dec.rs2 = Rs2D;
      dec.rd  = Instr_IFID[11:7];
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = alu_sel(Instr_IFID[14:12], Instr_IFID[30]);
         end
         OP_I: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = alu_sel(Instr_IFID[14:12], 1'b0);
            dec.imm       = {{20{Instr_IFID[31]}}, Instr_IFID[31:20]};
         end
         OP_LW: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
            dec.imm        = {{20{Instr_IFID[31]}}, Instr_IFID[31:20]};
         end
         OP_SW: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm       = {{20{Instr_IFID[31]}}, Instr_IFID[31:25], Instr_IFID[11:7]};
         end
         OP_BEQ: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = 3'b001;
            dec.imm      = {{19{Instr_IFID[31]}}, Instr_IFID[31], Instr_IFID[7],
                            Instr_IFID[30:25], Instr_IFID[11:8], 1'b0};
         end
         OP_JAL: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
            dec.imm        = {{11{Instr_IFID[31]}}, Instr_IFID[31], Instr_IFID[19:12],
                              Instr_IFID[20], Instr_IFID[30:21], 1'b0};
         end
         default: ; // unlisted opcode: control stays 0 (bubble)
      endcase
   end

   // Flush wins over the new decode; the whole register clears.
   assign idex_d = FlushE ? '0 : dec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign RegWrite_IDEX   = idex_q.reg_write;
   assign MemWrite_IDEX   = idex_q.mem_write;
   assign Jump_IDEX       = idex_q.jump;
   assign Branch_IDEX     = idex_q.branch;
   assign ALUSrc_IDEX     = idex_q.alu_src;
   assign ResultSrc_IDEX  = idex_q.result_src;
   assign ALUControl_IDEX = idex_q.alu_ctrl;
   assign RD1_IDEX        = idex_q.rd1;
   assign RD2_IDEX        = idex_q.rd2;
   assign ImmExt_IDEX     = idex_q.imm;
   assign PC_IDEX         = idex_q.pc;
   assign PCPlus4_IDEX    = idex_q.pc4;
   assign Rs1_IDEX        = idex_q.rs1;
   assign Rs2_IDEX        = idex_q.rs2;
   assign Rd_IDEX         = idex_q.rd;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage. Expected ID/EX contents
// are computed from a reference register file and decoder when stimulus is
// driven, queued, and compared after the capturing clock edge.
// Define ID_STAGE_WB_BYPASS_EN for both bench and RTL to check write-through.
// ---------------------------------------------------------------------------
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Instr_IFID, PC_IFID, ResultW;
   logic        FlushE, RegWriteW;
   logic [4:0]  RdW;
   logic [4:0]  Rs1D, Rs2D;
   logic        RegWrite_IDEX, MemWrite_IDEX, Jump_IDEX, Branch_IDEX, ALUSrc_IDEX;
   logic [1:0]  ResultSrc_IDEX;
   logic [2:0]  ALUControl_IDEX;
   logic [31:0] RD1_IDEX, RD2_IDEX, ImmExt_IDEX, PC_IDEX, PCPlus4_IDEX;
   logic [4:0]  Rs1_IDEX, Rs2_IDEX, Rd_IDEX;

   id_stage dut (
      .clk(clk), .rst(rst), .Instr_IFID(Instr_IFID), .PC_IFID(PC_IFID),
      .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .Rs1D(Rs1D), .Rs2D(Rs2D),
      .RegWrite_IDEX(RegWrite_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
      .Jump_IDEX(Jump_IDEX), .Branch_IDEX(Branch_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX),
      .ResultSrc_IDEX(ResultSrc_IDEX), .ALUControl_IDEX(ALUControl_IDEX),
      .RD1_IDEX(RD1_IDEX), .RD2_IDEX(RD2_IDEX), .ImmExt_IDEX(ImmExt_IDEX),
      .PC_IDEX(PC_IDEX), .PCPlus4_IDEX(PCPlus4_IDEX),
      .Rs1_IDEX(Rs1_IDEX), .Rs2_IDEX(Rs2_IDEX), .Rd_IDEX(Rd_IDEX)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw, mw, j, b, as;
      logic [1:0]  rs;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic        imm_chk;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rf [32];
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub);
      if (f3 == 3'b000) return sub ? 3'b001 : 3'b000;
      if (f3 == 3'b111) return 3'b010;
      if (f3 == 3'b110) return 3'b011;
      return 3'b101; // only 010 reaches here from the stimulus
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e = '{default: '0};
      e.imm_chk = 1'b1;
      return e;
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic fl, input logic we, input logic [4:0] wrd,
                                  input logic [31:0] wres);
      exp_t e;
      logic [4:0] r1, r2;
      e = zero_exp();
      if (fl) return e;
      r1 = ins[19:15];
      r2 = ins[24:20];
      e.rs1 = r1; e.rs2 = r2; e.rd = ins[11:7];
      e.rd1 = (r1 == 0) ? 32'h0 : rf[r1];
      e.rd2 = (r2 == 0) ? 32'h0 : rf[r2];
`ifdef ID_STAGE_WB_BYPASS_EN
      if (we && wrd != 0 && wrd == r1) e.rd1 = wres;
      if (we && wrd != 0 && wrd == r2) e.rd2 = wres;
`else
      if (we && wrd == 5'd31 && wres == 32'h1) e.rd1 = e.rd1; // no forwarding
`endif
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
      e.imm_chk = 1'b1;
      case (ins[6:0])
         7'b0110011: begin e.rw = 1; e.alu = ref_alu(ins[14:12], ins[30]); e.imm_chk = 0; end
         7'b0010011: begin e.rw = 1; e.as = 1; e.alu = ref_alu(ins[14:12], 1'b0);
                           e.imm = 32'($signed(ins) >>> 20); end
         7'b0000011: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = 32'($signed(ins) >>> 20); end
         7'b0100011: begin e.mw = 1; e.as = 1;
                           e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
         7'b1100011: begin e.b = 1; e.alu = 3'b001;
                           e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
         7'b1101111: begin e.rw = 1; e.j = 1; e.rs = 2'b10;
                           e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
         default:    e.imm_chk = 0;
      endcase
      return e;
   endfunction

   task automatic cmp(input string n);
      exp_t e;
      if (sb.size() == 0) begin
         chk({n, ".sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({n, ".rw"},  32'(RegWrite_IDEX),   32'(e.rw));
      chk({n, ".mw"},  32'(MemWrite_IDEX),   32'(e.mw));
      chk({n, ".j"},   32'(Jump_IDEX),       32'(e.j));
      chk({n, ".b"},   32'(Branch_IDEX),     32'(e.b));
      chk({n, ".as"},  32'(ALUSrc_IDEX),     32'(e.as));
      chk({n, ".rs"},  32'(ResultSrc_IDEX),  32'(e.rs));
      chk({n, ".alu"}, 32'(ALUControl_IDEX), 32'(e.alu));
      chk({n, ".rd1"}, RD1_IDEX, e.rd1);
      chk({n, ".rd2"}, RD2_IDEX, e.rd2);
      if (e.imm_chk) chk({n, ".imm"}, ImmExt_IDEX, e.imm);
      chk({n, ".pc"},  PC_IDEX, e.pc);
      chk({n, ".pc4"}, PCPlus4_IDEX, e.pc4);
      chk({n, ".rs1"}, 32'(Rs1_IDEX), 32'(e.rs1));
      chk({n, ".rs2"}, 32'(Rs2_IDEX), 32'(e.rs2));
      chk({n, ".rdx"}, 32'(Rd_IDEX),  32'(e.rd));
   endtask

   // Drive one cycle of stimulus (called #1 after a rising edge), capture, compare.
   task automatic step(input string n, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wres);
      Instr_IFID = ins; PC_IFID = pc; FlushE = fl;
      RegWriteW = we; RdW = wrd; ResultW = wres;
      sb.push_back(model(ins, pc, fl, we, wrd, wres));
      #1;
      chk({n, ".Rs1D"}, 32'(Rs1D), 32'(ins[19:15]));
      chk({n, ".Rs2D"}, 32'(Rs2D), 32'(ins[24:20]));
      @(posedge clk);
      if (we && wrd != 0) rf[wrd] = wres;
      #1;
      cmp(n);
   endtask

   logic [6:0] ops [8];
   logic [2:0] f3s [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
      ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0000000; ops[7] = 7'b1110011;
      f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110; f3s[3] = 3'b010;

      rst = 1'b1; Instr_IFID = 32'h0; PC_IFID = 32'h0; FlushE = 1'b0;
      RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
      #2;
      sb.push_back(zero_exp()); cmp("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // x5 = DEADBEEF, then add x6,x5,x0
      step("wr_x5", 32'h0, 32'h100, 0, 1, 5'd5, 32'hDEADBEEF);
      step("add", 32'h00028333, 32'h104, 0, 0, 5'd0, 32'h0);
      chk("add.rd1_const", RD1_IDEX, 32'hDEADBEEF);
      chk("add.rd_const", 32'(Rd_IDEX), 32'd6);
      chk("add.alu_const", 32'(ALUControl_IDEX), 32'd0);

      // lw x1,-4(x2)
      step("lw", 32'hFFC12083, 32'h108, 0, 0, 5'd0, 32'h0);
      chk("lw.imm_const", ImmExt_IDEX, 32'hFFFFFFFC);
      chk("lw.rs_const", 32'(ResultSrc_IDEX), 32'd1);

      // same-cycle WB and read of x7
      step("wr_x7", 32'h0, 32'h10C, 0, 1, 5'd7, 32'h11);
      step("wb_rd", 32'h00038433, 32'h110, 0, 1, 5'd7, 32'h55);
`ifdef ID_STAGE_WB_BYPASS_EN
      chk("wb_rd.rd1_const", RD1_IDEX, 32'h55);
`else
      chk("wb_rd.rd1_const", RD1_IDEX, 32'h11);
`endif
      step("rd_x7", 32'h00038433, 32'h114, 0, 0, 5'd0, 32'h0);
      chk("rd_x7.rd1_const", RD1_IDEX, 32'h55);

      // beq flushed, then not
      step("beq_fl", 32'h00208463, 32'h118, 1, 0, 5'd0, 32'h0);
      chk("beq_fl.b_const", 32'(Branch_IDEX), 32'd0);
      step("beq", 32'h00208463, 32'h118, 0, 0, 5'd0, 32'h0);
      chk("beq.b_const", 32'(Branch_IDEX), 32'd1);
      chk("beq.imm_const", ImmExt_IDEX, 32'd8);

      // x0 write ignored
      step("wr_x0", 32'h0, 32'h11C, 0, 1, 5'd0, 32'h1234);
      step("rd_x0", 32'h00000033, 32'h120, 0, 0, 5'd0, 32'h0);
      chk("rd_x0.rd1_const", RD1_IDEX, 32'h0);

      // jal x1,+2048 at wrapping PC
      step("jal", 32'h001000EF, 32'hFFFFFFFC, 0, 0, 5'd0, 32'h0);
      chk("jal.pc4_const", PCPlus4_IDEX, 32'h0);
      chk("jal.imm_const", ImmExt_IDEX, 32'h800);
      chk("jal.rs_const", 32'(ResultSrc_IDEX), 32'd2);

      // random mix with concurrent WB traffic
      for (int k = 0; k < 300; k++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 7)];
         if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011)
            ins[14:12] = f3s[$urandom_range(0, 3)];
         step("rand", ins, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
              5'($urandom_range(0, 31)), $urandom);
      end
      // make sure a few registers are non-zero before the reset test
      step("wr_x9", 32'h0, 32'h200, 0, 1, 5'd9, 32'hA5A5A5A5);

      // asynchronous reset mid-run, held across an edge
      Instr_IFID = 32'h00028333; FlushE = 1'b0; RegWriteW = 1'b0;
      rst = 1'b1;
      #2;
      sb.push_back(zero_exp()); cmp("rst_async");
      @(posedge clk); #1;
      sb.push_back(zero_exp()); cmp("rst_hold");
      rst = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      for (int r = 1; r < 32; r++) begin
         ins = 32'h00000033;
         ins[19:15] = 5'(r);
         ins[24:20] = 5'(r);
         step("post_rst", ins, 32'h300, 0, 0, 5'd0, 32'h0);
         chk("post_rst.rd1_const", RD1_IDEX, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
